// File: rtl/nand_arb_pkg.sv
// Shared types and constants for the four-way NAND arbiter.
package nand_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nand_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, scanning upward modulo NREQ.
module nand_rr_pick
  import nand_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win
);

  logic [IDX_W-1:0] cand;

  // Scan from the lowest priority to the highest so the last hit is the winner.
  always_comb begin
    any  = |req;
    win  = '0;
    cand = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      cand = ptr + IDX_W'(i - 1);
      if (req[cand]) win = cand;
    end
  end

endmodule

// File: rtl/tt_um_akaur014_nand_arb.sv
// Round-robin sequencer sharing one registered NAND unit among four requesters on the tt_um pins.
module tt_um_akaur014_nand_arb
  import nand_arb_pkg::*;
#(
  parameter int NREQ = nand_arb_pkg::NREQ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [NREQ-1:0]  req;
  logic             hold;
  logic             pick_any;
  logic [IDX_W-1:0] pick_win;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic             opa_q;
  logic             opb_q;
  logic             yr_q;

  logic             valid_q;
  logic [NREQ-1:0]  gnt_q;
  logic             y_q;
  logic [IDX_W-1:0] idx_out_q;

  assign req  = ui_in[NREQ-1:0];
  assign hold = ui_in[4];

  nand_rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  // Result strobe is loaded while in DONE, so it is visible the cycle after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      opa_q     <= 1'b0;
      opb_q     <= 1'b0;
      yr_q      <= 1'b0;
      valid_q   <= 1'b0;
      gnt_q     <= '0;
      y_q       <= 1'b0;
      idx_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      gnt_q   <= '0;
      case (state_q)
        IDLE: begin
          if (!hold && pick_any) begin
            opa_q   <= uio_in[{pick_win, 1'b0}];
            opb_q   <= uio_in[{pick_win, 1'b1}];
            idx_q   <= pick_win;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          yr_q    <= ~(opa_q & opb_q);
          state_q <= DONE;
        end
        DONE: begin
          valid_q   <= 1'b1;
          gnt_q     <= NREQ'(1) << idx_q;
          y_q       <= yr_q;
          idx_out_q <= idx_q;
          ptr_q     <= idx_q + IDX_W'(1);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uo_out  = {idx_out_q, valid_q, y_q, gnt_q};
  assign uio_out = '0;
  assign uio_oe  = '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:5]};

endmodule
